// File: rtl/adel_pkg.sv
// adel_pkg: types and constants shared by the adel core and its run sequencer
package adel_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0] HALT_NONE    = 2'b00;
    localparam logic [1:0] HALT_LOOP    = 2'b01;
    localparam logic [1:0] HALT_END     = 2'b10;
    localparam logic [1:0] HALT_TIMEOUT = 2'b11;

endpackage

// File: rtl/adel_imem.sv
// adel_imem: instruction store with one synchronous write port and one combinational read port
module adel_imem
    import adel_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    word_t r_mem [DEPTH];

    // program words are written one per cycle while loading; contents survive reset
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/adel_seq.sv
// adel_seq: program loader and run sequencer that holds the adel core in reset and detects termination
module adel_seq
    import adel_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int AW         = 6,
    parameter int MAX_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        load_start,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic        load_last,
    input  logic        run,
    output logic        busy,
    output logic        done,
    output logic [1:0]  halt_reason,
    output logic [15:0] final_pc,
    output logic [15:0] cycles,
    output logic [AW:0] prog_len,
    output logic        core_nrst,
    input  logic [15:0] core_pc,
    output logic [15:0] core_inst
);

    seq_state_t    r_state;
    logic [AW-1:0] r_wptr;
    logic [AW:0]   r_prog_len;
    logic [1:0]    r_halt_reason;
    word_t         r_final_pc;
    word_t         r_cycles;
    word_t         r_prev_pc;
    logic          r_core_nrst;

    logic          w_we;
    logic          w_in_prog;
    logic          w_loop;
    logic          w_end;
    logic          w_tmo;
    word_t         w_rdata;

    assign w_we      = (r_state == ST_LOAD) && load_valid;
    assign w_in_prog = core_pc < 16'(r_prog_len);
    // r_cycles equals the number of RUN cycles so far, so it doubles as the self-loop guard
    assign w_loop    = (r_cycles != '0) && (core_pc == r_prev_pc);
    assign w_end     = !w_in_prog;
    assign w_tmo     = r_cycles == 16'(MAX_CYCLES);

    adel_imem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (load_data),
        .i_raddr (core_pc[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign load_ready  = r_state == ST_LOAD;
    assign busy        = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign done        = r_state == ST_DONE;
    assign halt_reason = r_halt_reason;
    assign final_pc    = r_final_pc;
    assign cycles      = r_cycles;
    assign prog_len    = r_prog_len;
    assign core_nrst   = r_core_nrst;
    assign core_inst   = (r_state == ST_RUN && w_in_prog) ? w_rdata : 16'h0000;

    // sequencer FSM: load, release the core, watch its pc and park results on halt
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= ST_IDLE;
            r_wptr        <= '0;
            r_prog_len    <= '0;
            r_halt_reason <= HALT_NONE;
            r_final_pc    <= '0;
            r_cycles      <= '0;
            r_prev_pc     <= '0;
            r_core_nrst   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (load_start) begin
                        r_state       <= ST_LOAD;
                        r_wptr        <= '0;
                        r_prog_len    <= '0;
                        r_halt_reason <= HALT_NONE;
                    end else if (run && r_prog_len != '0) begin
                        r_state     <= ST_RUN;
                        r_cycles    <= '0;
                        r_core_nrst <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        r_wptr <= r_wptr + 1'b1;
                        if (load_last || &r_wptr) begin
                            r_prog_len <= {1'b0, r_wptr} + 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_loop || w_end || w_tmo) begin
                        r_final_pc    <= core_pc;
                        r_halt_reason <= w_loop ? HALT_LOOP : w_end ? HALT_END : HALT_TIMEOUT;
                        r_core_nrst   <= 1'b0;
                        r_state       <= ST_DONE;
                    end else begin
                        r_cycles  <= r_cycles + 1'b1;
                        r_prev_pc <= core_pc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/adel_seq.md
# adel_seq

Program loader and run sequencer for the `adel` 16-bit core. It owns a small instruction memory, accepts a program over a valid/ready stream, and holds the core in reset while loading. On command it releases the core, serves instructions combinationally from the core's `pc`, and detects termination: a self-loop, running off the end of the program, or a cycle-limit timeout. It sits between the test/host interface and one `adel` instance.

## Interface
- `DEPTH`, 64: instruction memory words; power of two.
- `AW`, 6: address width, equal to log2(`DEPTH`).
- `MAX_CYCLES`, 1024: run-cycle limit before timeout; at most 65535.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `load_start` in 1: pulse; begin a new program load.
- `load_valid` in 1: load beat valid.
- `load_ready` out 1: load beat accepted when high together with `load_valid`.
- `load_data` in 16: instruction word.
- `load_last` in 1: marks the final word of the program.
- `run` in 1: pulse; execute the loaded program.
- `busy` out 1: high in LOAD or RUN.
- `done` out 1: high in DONE.
- `halt_reason` out 2: 00 none, 01 self-loop, 10 end of program, 11 timeout.
- `final_pc` out 16: core `pc` at the halt cycle.
- `cycles` out 16: instructions executed in the last run.
- `prog_len` out AW+1: number of loaded words.
- `core_nrst` out 1: reset to the core; registered.
- `core_pc` in 16: `pc` from the core.
- `core_inst` out 16: instruction to the core.

## Operation
- States are IDLE, LOAD, RUN and DONE. After reset the state is IDLE.
- Reset values:
  - all outputs 0, including `core_nrst=0`;
  - `prog_len=0`.
  - Memory contents are not reset.
- **IDLE or DONE:**
  - `load_start` goes to LOAD and clears the write pointer.
  - `run` with `prog_len!=0` goes to RUN.
  - `run` with `prog_len==0` is ignored.
  - If `load_start` and `run` are both high, `load_start` wins.
- **LOAD:**
  - `load_ready=1`.
  - Each accepted beat writes `imem[wptr]` and increments `wptr`.
  - A beat with `load_last`, or the beat at `wptr==DEPTH-1`, sets `prog_len=wptr+1` and returns to IDLE.
  - `run` and `load_start` are ignored in LOAD.
  - `done`, `halt_reason` and `prog_len` are cleared on LOAD entry.
- **RUN:**
  - `core_nrst=1`.
  - `core_inst = imem[core_pc[AW-1:0]]` when `core_pc<prog_len`, otherwise 16'h0000.
  - Each RUN cycle evaluates the following, in priority order:
    - run-cycle count is not 0 and `core_pc==prev_pc` -> self-loop (01);
    - else `core_pc>=prog_len` -> end (10);
    - else `cycles==MAX_CYCLES` -> timeout (11);
    - else `cycles` increments and `prev_pc<=core_pc`.
  - On a halt:
    - `final_pc<=core_pc` and `halt_reason` is set;
    - `core_nrst<=0`;
    - the next state is DONE.
- **DONE:**
  - `done=1`, and the core is held in reset.
  - Results hold until the next `load_start` or `run`.
  - RUN entry clears `cycles` and the run-cycle count.
- Asserting `nrst` mid-operation aborts immediately to IDLE with `prog_len=0`.

## Timing
- `core_nrst` is registered:
  - it rises on the edge that enters RUN;
  - it falls on the edge that enters DONE.
- The first RUN cycle sees `core_pc=0` (the core has just left reset), and the core executes `imem[0]` at the end of that cycle.
- A halt decision uses the current-cycle `core_pc`. The halt-cycle instruction is not counted, and the core is reset at that edge.
- Load throughput is one word per cycle; `load_ready` is high from the cycle after `load_start`.
- `busy`, `done` and `load_ready` are decoded directly from the state register.

## Structure
- Package `adel_pkg`:
  - state enum `seq_state_t`;
  - halt-reason constants `HALT_NONE`, `HALT_LOOP`, `HALT_END`, `HALT_TIMEOUT`;
  - the 16-bit word type shared with `adel`.
- One sub-module, `adel_imem`: DEPTH x 16 memory with one synchronous write port and one combinational read port.
- The FSM, counters and halt logic live in `adel_seq`.

## Test plan
- Load [16'h8405, 16'h2100], then `run` -> `done` with `halt_reason=01`, `final_pc=1`, `cycles=2`, `prog_len=2`.
- Load [16'h8405], then `run` -> `halt_reason=10`, `final_pc=1`, `cycles=1`.
- With `MAX_CYCLES=8`, load [16'h8401, 16'h21FF], then `run` -> `halt_reason=11`, `cycles=8`, with `core_nrst` low in the following cycle.
- Stream 70 words without `load_last` at `DEPTH=64` -> `prog_len=64` after the 64th beat, back in IDLE with `load_ready=0`, and the extra beats are not accepted.
- `run` after reset with `prog_len=0` -> the block stays in IDLE and `core_nrst` stays 0. `load_start` and `run` in the same cycle -> LOAD.
- Drop `nrst` three cycles into RUN -> IDLE asynchronously, all outputs 0, `prog_len=0`, `core_nrst=0`.
